// File: rtl/warrior_loader_pkg.sv
// Shared constants for the warrior loader: write-enable patterns, defaults, length check.
package warrior_loader_pkg;

    localparam int DEF_CORESIZE   = 8000;
    localparam int DEF_MAX_LENGTH = 100;

    localparam logic [5:0] WE_ALL  = 6'h3F;
    localparam logic [5:0] WE_NONE = 6'h00;

    function automatic logic len_in_range(input int len, input int max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/warrior_loader_core_addr_counter.sv
// Modulo-CORESIZE address counter with synchronous load and increment enable.
module core_addr_counter
    import warrior_loader_pkg::*;
#(
    parameter int CORESIZE   = DEF_CORESIZE,
    parameter int ADDR_WIDTH = $clog2(CORESIZE)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_load_val,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_cnt
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CORESIZE - 1);

    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // Compare-and-wrap so a non power-of-two core never sees an out-of-range address.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load)
            cnt_d = i_load_val;
        else if (i_inc)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ADDR_WIDTH'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/warrior_loader.sv
// Core write master: optional full-core clear, then streams one warrior from base upward.
module warrior_loader
    import warrior_loader_pkg::*;
#(
    parameter int CORESIZE    = DEF_CORESIZE,
    parameter int MAX_LENGTH  = DEF_MAX_LENGTH,
    parameter int ADDR_WIDTH  = $clog2(CORESIZE),
    parameter int INSTR_WIDTH = 14 + 2 * ADDR_WIDTH,
    parameter int LEN_WIDTH   = $clog2(MAX_LENGTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_clear_en,
    input  logic [ADDR_WIDTH-1:0]  i_base,
    input  logic [LEN_WIDTH-1:0]   i_len,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic                   i_instr_valid,
    output logic                   o_instr_ready,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [ADDR_WIDTH-1:0]  o_woffs,
    output logic [INSTR_WIDTH-1:0] o_din,
    output logic [5:0]             o_we,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // DAT.F $0,$0 packs to all zeros.
    localparam logic [INSTR_WIDTH-1:0] CLEAR_INSTR = '0;
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR   = ADDR_WIDTH'(CORESIZE - 1);

    logic [1:0]             state_q, state_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] din_q, din_d;
    logic [5:0]             we_q, we_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                  start_ok;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] clr_cnt, ld_addr;

    assign start_ok = (state_q == ST_IDLE) && i_start && len_in_range(int'(i_len), MAX_LENGTH);
    assign accept   = (state_q == ST_LOAD) && i_instr_valid;

    core_addr_counter #(.CORESIZE(CORESIZE), .ADDR_WIDTH(ADDR_WIDTH)) u_clr_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (start_ok),
        .i_load_val ('0),
        .i_inc      (state_q == ST_CLEAR),
        .o_cnt      (clr_cnt)
    );

    core_addr_counter #(.CORESIZE(CORESIZE), .ADDR_WIDTH(ADDR_WIDTH)) u_ld_addr (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (start_ok),
        .i_load_val (i_base),
        .i_inc      (accept),
        .o_cnt      (ld_addr)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pc_d    = pc_q;
        din_d   = din_q;
        we_d    = WE_NONE;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    rem_d   = i_len;
                    state_d = i_clear_en ? ST_CLEAR : ST_LOAD;
                end else if (i_start) begin
                    err_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                we_d  = WE_ALL;
                pc_d  = clr_cnt;
                din_d = CLEAR_INSTR;
                if (clr_cnt == LAST_ADDR)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept) begin
                    we_d  = WE_ALL;
                    pc_d  = ld_addr;
                    din_d = i_instr;
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1))
                        state_d = ST_DRAIN;
                end
            end
            default: begin
                // Last write is on the bus this cycle; the core commits it at this edge.
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            pc_q    <= '0;
            din_q   <= '0;
            we_q    <= WE_NONE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pc_q    <= pc_d;
            din_q   <= din_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_pc          = pc_q;
    assign o_woffs       = '0;
    assign o_din         = din_q;
    assign o_we          = we_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_instr_ready = (state_q == ST_LOAD);
    assign o_done        = done_q;
    assign o_err         = err_q;

endmodule
